// File: rtl/step_cmd_gen.sv
// step_cmd_gen: debounced push-button front end for the 8-bit up/down counter.
// Three raw buttons are synchronised and debounced, and each accepted press
// becomes one single-cycle step strobe with stable dir/clr levels around it.
// Optional feature macro: STEP_AUTOREPEAT_EN (auto-repeat while up or down is
// held). With the macro undefined, exactly one step is issued per press.
module step_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 5000,
  parameter int REPEAT_PERIOD   = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_clr,
  output logic step,
  output logic dir,
  output logic clr,
  output logic busy
);

  localparam logic [15:0] DEB_MAX = 16'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    QUAL = 3'd1,
    ARM  = 3'd2,
    FIRE = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [2:0]  sync1_r;     // first synchroniser stage, {clr, up, down}
  logic [2:0]  vec_r;       // synchronised button vector, {clr, up, down}
  logic [15:0] stable_r;    // cycles the synchronised vector has been unchanged
  logic        stable_s;
  logic        dir_r;
  logic        clr_r;
  logic        cmd_ok_r;    // qualified vector decoded to a real command
  logic        step_r;
  logic        busy_r;
  logic        dec_ok_s;
  logic        dec_dir_s;
  logic        dec_clr_s;
  logic        rep_fire_s;

  assign stable_s = (stable_r == DEB_MAX);

  // Two-flop synchroniser for each raw button.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 3'b000;
      vec_r   <= 3'b000;
    end else begin
      sync1_r <= {btn_clr, btn_up, btn_down};
      vec_r   <= sync1_r;
    end
  end

  // Shared stable counter: restarts when the vector is about to change,
  // otherwise counts up and saturates at the debounce length.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_r <= 16'd0;
    end else if (sync1_r != vec_r) begin
      stable_r <= 16'd0;
    end else if (stable_r != DEB_MAX) begin
      stable_r <= stable_r + 16'd1;
    end else begin
      stable_r <= stable_r;
    end
  end

  // Decode the qualified vector: clear wins, then a lone up or lone down.
  always_comb begin
    dec_ok_s  = 1'b0;
    dec_dir_s = dir_r;
    dec_clr_s = clr_r;
    if (vec_r[2]) begin
      dec_ok_s  = 1'b1;
      dec_dir_s = 1'b0;
      dec_clr_s = 1'b1;
    end else if (vec_r[1:0] == 2'b10) begin
      dec_ok_s  = 1'b1;
      dec_dir_s = 1'b0;
      dec_clr_s = 1'b0;
    end else if (vec_r[1:0] == 2'b01) begin
      dec_ok_s  = 1'b1;
      dec_dir_s = 1'b1;
      dec_clr_s = 1'b0;
    end else begin
      dec_ok_s  = 1'b0;
      dec_dir_s = dir_r;
      dec_clr_s = clr_r;
    end
  end

  // Press-handling state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (vec_r != 3'b000) begin
          state_s = QUAL;
        end else begin
          state_s = IDLE;
        end
      end
      QUAL: begin
        if (vec_r == 3'b000) begin
          state_s = IDLE;
        end else if (stable_s) begin
          state_s = ARM;
        end else begin
          state_s = QUAL;
        end
      end
      ARM: begin
        if (cmd_ok_r) begin
          state_s = FIRE;
        end else begin
          state_s = HOLD;
        end
      end
      FIRE: begin
        state_s = HOLD;
      end
      HOLD: begin
        if ((vec_r == 3'b000) && stable_s) begin
          state_s = IDLE;
        end else if (rep_fire_s) begin
          state_s = FIRE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Latch dir/clr on entry to ARM so they are stable a full cycle before step.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_r    <= 1'b0;
      clr_r    <= 1'b0;
      cmd_ok_r <= 1'b0;
    end else if ((state_r == QUAL) && (state_s == ARM)) begin
      dir_r    <= dec_dir_s;
      clr_r    <= dec_clr_s;
      cmd_ok_r <= dec_ok_s;
    end else begin
      dir_r    <= dir_r;
      clr_r    <= clr_r;
      cmd_ok_r <= cmd_ok_r;
    end
  end

  // Registered strobe and busy flag, both driven from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      step_r <= (state_s == FIRE);
      busy_r <= (state_s != IDLE);
    end
  end

`ifdef STEP_AUTOREPEAT_EN
  localparam logic [15:0] DELAY_M1  = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] PERIOD_M1 = 16'(REPEAT_PERIOD - 1);

  logic [15:0] rpt_r;        // cycles since the most recent FIRE
  logic        rpt_ok_r;     // repeats still allowed for this press
  logic        rpt_first_r;  // next repeat is the first one (uses the delay)
  logic [2:0]  rpt_match_s;
  logic [15:0] rpt_limit_s;

  // Repeat condition: the same single up/down button still held and the
  // interval since the last FIRE has elapsed.
  always_comb begin
    rpt_match_s = dir_r ? 3'b001 : 3'b010;
    rpt_limit_s = rpt_first_r ? DELAY_M1 : PERIOD_M1;
    if (rpt_ok_r && (vec_r == rpt_match_s) && (rpt_r == rpt_limit_s)) begin
      rep_fire_s = 1'b1;
    end else begin
      rep_fire_s = 1'b0;
    end
  end

  // Repeat counter: armed by a non-clear command, killed by any other vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_r       <= 16'd0;
      rpt_ok_r    <= 1'b0;
      rpt_first_r <= 1'b0;
    end else if ((state_r == QUAL) && (state_s == ARM)) begin
      rpt_r       <= 16'd0;
      rpt_ok_r    <= dec_ok_s & ~dec_clr_s;
      rpt_first_r <= 1'b1;
    end else if (state_r == FIRE) begin
      rpt_r <= 16'd1;
    end else if (state_r == HOLD) begin
      if (state_s == FIRE) begin
        rpt_first_r <= 1'b0;
      end else if (rpt_ok_r && (vec_r == rpt_match_s)) begin
        rpt_r <= rpt_r + 16'd1;
      end else begin
        rpt_ok_r <= 1'b0;
      end
    end else begin
      rpt_r <= rpt_r;
    end
  end
`else
  logic unused_cfg_s;
  assign rep_fire_s   = 1'b0;
  assign unused_cfg_s = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  assign step = step_r;
  assign dir  = dir_r;
  assign clr  = clr_r;
  assign busy = busy_r;

endmodule

// File: tb/tb_step_cmd_gen.sv
// Self-checking bench for step_cmd_gen: directed scenarios with hand-derived
// latencies plus randomized button activity, all checked every cycle against
// an event/timestamp model of press qualification, strobe and release.
module tb_step_cmd_gen;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_clr = 1'b0;
  logic step, dir, clr, busy;

  step_cmd_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .btn_clr(btn_clr), .step(step), .dir(dir), .clr(clr), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ek    = 0;   // rising-edge number

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ek);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [2:0] m_s1, m_vec, m_match, pv;
  bit m_valid, m_busy, m_qual, m_step, m_dir, m_clr, m_rep_ok, m_rep_first;
  int m_lastchg, m_fire_at, m_check_from, m_last_fire, age, pre_cnt;

  always @(posedge clk) begin
    ek = ek + 1;
    pv = m_vec;
    age = ek - 1 - m_lastchg;
    pre_cnt = (age > D) ? D : age;
    if (reset) begin
      m_valid = 1; m_busy = 0; m_qual = 0; m_step = 0; m_dir = 0; m_clr = 0;
      m_rep_ok = 0; m_rep_first = 0; m_fire_at = 0; m_check_from = 0;
      m_s1 = 0; m_vec = 0; m_lastchg = ek;
    end else begin
      m_step = 0;
      if (!m_busy) begin
        if (pv != 0) begin m_busy = 1; m_qual = 1; end
      end else if (m_qual) begin
        if (pv == 0) begin
          m_busy = 0; m_qual = 0;
        end else if (pre_cnt == D) begin
          m_qual = 0;
          if (pv[2])           begin m_clr = 1; m_dir = 0; m_match = 3'b000; end
          else if (pv == 3'b010) begin m_clr = 0; m_dir = 0; m_match = 3'b010; end
          else if (pv == 3'b001) begin m_clr = 0; m_dir = 1; m_match = 3'b001; end
          else m_match = 3'b111;  // up+down: no command
          if (m_match != 3'b111) begin
            m_fire_at = ek + 1; m_last_fire = ek + 1; m_check_from = ek + 3;
            m_rep_ok = (m_match != 3'b000); m_rep_first = 1;
          end else begin
            m_fire_at = 0; m_check_from = ek + 2; m_rep_ok = 0;
          end
        end
      end else if (ek == m_fire_at) begin
        m_step = 1;
      end else if (ek >= m_check_from) begin
        if (pv == 0 && pre_cnt == D) begin
          m_busy = 0;
        end
`ifdef STEP_AUTOREPEAT_EN
        else if (m_rep_ok && pv == m_match) begin
          if (ek == m_last_fire + (m_rep_first ? RD : RP)) begin
            m_step = 1; m_rep_first = 0; m_last_fire = ek; m_check_from = ek + 2;
          end
        end else begin
          m_rep_ok = 0;
        end
`endif
      end
      if (m_s1 != m_vec) m_lastchg = ek;
      m_vec = m_s1;
      m_s1 = {btn_clr, btn_up, btn_down};
    end
  end

  // ---------------- compare + monitor ----------------
  int n_steps = 0, last_step_edge = 0, busy_fall_edge = 0;
  logic step_dir = 1'b0, step_clr = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (m_valid) begin
      chk("step", step, m_step);
      chk("dir",  dir,  m_dir);
      chk("clr",  clr,  m_clr);
      chk("busy", busy, m_busy);
    end
    if (step === 1'b1) begin
      n_steps++; last_step_edge = ek; step_dir = dir; step_clr = clr;
    end
    if (prev_busy === 1'b1 && busy === 1'b0) busy_fall_edge = ek;
    prev_busy = busy;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 200) begin cyc(1); k++; end
    chk(name, busy, 1'b0);
    cyc(1);
  endtask

  int press, rel, s0, rd, found;

  initial begin
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(3);
    chk("rst_step", step, 0); chk("rst_dir", dir, 0);
    chk("rst_clr", clr, 0);   chk("rst_busy", busy, 0);

    // up press: latency D+3, dir=0 clr=0, busy drops D+2 edges after release
    s0 = n_steps; btn_up = 1'b1; press = ek + 1;
    cyc(20);
    btn_up = 1'b0; rel = ek + 1;
    cyc(2);
    chk("t1_nstep", n_steps - s0, 1);
    chk("t1_latency", last_step_edge - press, D + 3);
    chk("t1_dir", step_dir, 0); chk("t1_clr", step_clr, 0);
    wait_idle("t1_idle");
    chk("t1_busy_fall", busy_fall_edge - rel, D + 2);

    // bouncing down button, then a stable hold
    s0 = n_steps;
    for (int i = 0; i < 10; i++) begin btn_down = ~btn_down; cyc(2); end
    cyc(1);
    chk("t2_bounce_nostep", n_steps - s0, 0);
    btn_down = 1'b1; press = ek + 1;
    cyc(15);
    chk("t2_nstep", n_steps - s0, 1);
    chk("t2_dir", step_dir, 1);
    chk("t2_latency", last_step_edge - press, D + 3);
    btn_down = 1'b0;
    wait_idle("t2_idle");

    // clear+up, then down
    s0 = n_steps; btn_clr = 1'b1; btn_up = 1'b1;
    cyc(12);
    chk("t3_nstep", n_steps - s0, 1);
    chk("t3_clr", step_clr, 1); chk("t3_dir", step_dir, 0);
    btn_clr = 1'b0; btn_up = 1'b0;
    wait_idle("t3_idle");
    btn_down = 1'b1;
    cyc(12);
    chk("t3b_clr", step_clr, 0); chk("t3b_dir", step_dir, 1);
    btn_down = 1'b0;
    wait_idle("t3b_idle");

    // up+down together: no command
    s0 = n_steps; btn_up = 1'b1; btn_down = 1'b1;
    cyc(15);
    btn_up = 1'b0; btn_down = 1'b0;
    wait_idle("t4_idle");
    chk("t4_nostep", n_steps - s0, 0);

    // reset during the FIRE cycle
    btn_up = 1'b1; found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      cyc(1);
      if (step === 1'b1) found = 1;
    end
    chk("t5_found", found, 1);
    reset = 1'b1;
    cyc(1);
    chk("t5_step0", step, 0); chk("t5_busy0", busy, 0);
    reset = 1'b0; rd = ek + 1;
    cyc(D + 6);
    chk("t5_relatency", last_step_edge - rd, D + 3);
    btn_up = 1'b0;
    wait_idle("t5_idle");

    // long hold: auto-repeat only with the feature enabled
    s0 = n_steps; btn_up = 1'b1; press = ek + 1;
    cyc(60);
    btn_up = 1'b0;
    wait_idle("t6_idle");
`ifdef STEP_AUTOREPEAT_EN
    chk("t6_nstep", n_steps - s0, 6);
    chk("t6_last", last_step_edge - press, D + 3 + 52);
`else
    chk("t6_nstep", n_steps - s0, 1);
`endif

    // randomized activity
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 3)      {btn_clr, btn_up, btn_down} = 3'b000;
      else if (r < 5) {btn_clr, btn_up, btn_down} = 3'b010;
      else if (r < 7) {btn_clr, btn_up, btn_down} = 3'b001;
      else            {btn_clr, btn_up, btn_down} = 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 39) == 0);
      cyc(1);
      reset = 1'b0;
      cyc($urandom_range(0, 13));
    end
    {btn_clr, btn_up, btn_down} = 3'b000;
    wait_idle("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
